// File: rtl/serial_sub_if.sv
// Handshake and operand/result bundle for the bit-serial subtractor.
interface serial_sub_if #(
    parameter int W = 8
);
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] d;
    logic         bo;
    logic         ovf;
    logic         busy;
    logic         done;

    modport master (
        output start, a, b,
        input  d, bo, ovf, busy, done
    );

    modport slave (
        input  start, a, b,
        output d, bo, ovf, busy, done
    );
endinterface

// File: rtl/serial_sub.sv
// Bit-serial W-bit subtractor D = A - B, LSB first, one full-subtractor
// cell plus a borrow flop, with start/busy/done handshake.
module serial_sub #(
    parameter int W = 8
) (
    input  logic      clk,
    input  logic      rst,
    serial_sub_if.slave bus
);
    localparam int CW = (W > 2) ? $clog2(W) : 1;
    localparam logic [CW-1:0] LAST = CW'(W - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_e;

    state_e        state_q, state_d;
    logic [W-1:0]  sa_q, sa_d;
    logic [W-1:0]  sb_q, sb_d;
    logic [W-1:0]  res_q, res_d;
    logic [W-1:0]  d_q, d_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          borrow_q, borrow_d;
    logic          amsb_q, amsb_d;
    logic          bmsb_q, bmsb_d;
    logic          bo_q, bo_d;
    logic          ovf_q, ovf_d;
    logic          diff;
    logic          borrow_nx;

    always_comb begin
        state_d   = state_q;
        sa_d      = sa_q;
        sb_d      = sb_q;
        res_d     = res_q;
        d_d       = d_q;
        cnt_d     = cnt_q;
        borrow_d  = borrow_q;
        amsb_d    = amsb_q;
        bmsb_d    = bmsb_q;
        bo_d      = bo_q;
        ovf_d     = ovf_q;
        diff      = sa_q[0] ^ sb_q[0] ^ borrow_q;
        borrow_nx = (~sa_q[0] & sb_q[0])
                  | (~(sa_q[0] ^ sb_q[0]) & borrow_q);

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    sa_d     = bus.a;
                    sb_d     = bus.b;
                    borrow_d = 1'b0;
                    cnt_d    = '0;
                    amsb_d   = bus.a[W-1];
                    bmsb_d   = bus.b[W-1];
                    state_d  = RUN;
                end
            end
            RUN: begin
                sa_d     = sa_q >> 1;
                sb_d     = sb_q >> 1;
                res_d    = {diff, res_q[W-1:1]};
                borrow_d = borrow_nx;
                cnt_d    = cnt_q + 1'b1;
                // Results are published only on entry to DONE so they
                // stay stable while the next operation runs.
                if (cnt_q == LAST) begin
                    state_d = DONE;
                    d_d     = {diff, res_q[W-1:1]};
                    bo_d    = borrow_nx;
                    ovf_d   = (amsb_q != bmsb_q) && (diff != amsb_q);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            sa_q     <= '0;
            sb_q     <= '0;
            res_q    <= '0;
            d_q      <= '0;
            cnt_q    <= '0;
            borrow_q <= 1'b0;
            amsb_q   <= 1'b0;
            bmsb_q   <= 1'b0;
            bo_q     <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            res_q    <= res_d;
            d_q      <= d_d;
            cnt_q    <= cnt_d;
            borrow_q <= borrow_d;
            amsb_q   <= amsb_d;
            bmsb_q   <= bmsb_d;
            bo_q     <= bo_d;
            ovf_q    <= ovf_d;
        end
    end

    assign bus.d    = d_q;
    assign bus.bo   = bo_q;
    assign bus.ovf  = ovf_q;
    assign bus.busy = (state_q == RUN);
    assign bus.done = (state_q == DONE);
endmodule

// File: tb/tb_serial_sub.sv
// Self-checking bench for serial_sub at W=4 against an arithmetic
// reference model of unsigned/signed subtraction.
module tb_serial_sub;
    localparam int W = 4;
    localparam int P = W + 2;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;

    serial_sub_if #(.W(W)) bus ();

    serial_sub #(.W(W)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic ref_sub(
        input  logic [W-1:0] a,
        input  logic [W-1:0] b,
        output logic [W-1:0] d,
        output logic         bo,
        output logic         ovf
    );
        int ua, ub, sa, sb, sd, ud;
        ua  = int'(a);
        ub  = int'(b);
        sa  = (ua >= (1 << (W - 1))) ? ua - (1 << W) : ua;
        sb  = (ub >= (1 << (W - 1))) ? ub - (1 << W) : ub;
        sd  = sa - sb;
        ud  = (ua - ub) & ((1 << W) - 1);
        d   = ud[W-1:0];
        bo  = (ua < ub);
        ovf = (sd < -(1 << (W - 1))) || (sd > (1 << (W - 1)) - 1);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issues one operation and waits for its done pulse; scrambles a/b
    // right after acceptance. Returns outputs seen during done.
    task automatic do_op(
        input  logic [W-1:0] a,
        input  logic [W-1:0] b,
        output logic [W-1:0] d,
        output logic         bo,
        output logic         ovf,
        output int           nbusy,
        output int           overlap,
        output bit           tmo
    );
        int k;
        tmo     = 1'b1;
        nbusy   = 0;
        overlap = 0;
        d       = '0;
        bo      = 1'b0;
        ovf     = 1'b0;
        bus.start = 1'b1;
        bus.a     = a;
        bus.b     = b;
        for (k = 0; k < 4; k++) begin
            tick();
            if (bus.busy) break;
        end
        bus.start = 1'b0;
        bus.a     = W'($urandom);
        bus.b     = W'($urandom);
        for (k = 0; k < 3 * P; k++) begin
            if (bus.busy && bus.done) overlap++;
            if (bus.busy) nbusy++;
            if (bus.done) begin
                d   = bus.d;
                bo  = bus.bo;
                ovf = bus.ovf;
                tmo = 1'b0;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        tick();
        tick();
        n_cmp++;
        if ({bus.d, bus.bo, bus.ovf, bus.busy, bus.done} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs got d=%h bo=%b ovf=%b busy=%b done=%b want all 0",
                     bus.d, bus.bo, bus.ovf, bus.busy, bus.done);
        end
        rst = 1'b0;
        tick();
        n_cmp++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            n_bad++;
            $display("FAIL idle_no_start got busy=%b done=%b want 0 0",
                     bus.busy, bus.done);
        end
    endtask

    task automatic test_directed();
        logic [W-1:0] ta[4] = '{4'd5, 4'd3, 4'd8, 4'd7};
        logic [W-1:0] tb_[4] = '{4'd3, 4'd5, 4'd1, 4'd15};
        logic [W-1:0] ed[4] = '{4'd2, 4'd14, 4'd7, 4'd8};
        logic         eb[4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        logic         eo[4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        logic [W-1:0] d;
        logic         bo, ovf;
        int           nb, ov;
        bit           tmo;
        for (int i = 0; i < 4; i++) begin
            do_op(ta[i], tb_[i], d, bo, ovf, nb, ov, tmo);
            n_cmp++;
            if (tmo) begin
                n_bad++;
                $display("FAIL directed_timeout case %0d got no done want done", i);
            end
            n_cmp++;
            if ({d, bo, ovf} !== {ed[i], eb[i], eo[i]}) begin
                n_bad++;
                $display("FAIL directed_result a=%0d b=%0d got d=%0d bo=%b ovf=%b want d=%0d bo=%b ovf=%b",
                         ta[i], tb_[i], d, bo, ovf, ed[i], eb[i], eo[i]);
            end
            n_cmp++;
            if (nb !== W || ov !== 0) begin
                n_bad++;
                $display("FAIL directed_busy case %0d got busy_cycles=%0d overlap=%0d want %0d 0",
                         i, nb, ov, W);
            end
            tick();
            n_cmp++;
            if (bus.done !== 1'b0 || {bus.d, bus.bo, bus.ovf} !== {ed[i], eb[i], eo[i]}) begin
                n_bad++;
                $display("FAIL directed_hold case %0d got done=%b d=%0d want done=0 d=%0d",
                         i, bus.done, bus.d, ed[i]);
            end
        end
    endtask

    task automatic test_held_start();
        logic [W-1:0] oa[5*P];
        logic [W-1:0] ob[5*P];
        logic [W-1:0] ed;
        logic         eb, eo;
        int           ph, k;
        rst = 1'b1;
        tick();
        rst       = 1'b0;
        bus.start = 1'b1;
        for (int i = 0; i < 5 * P; i++) begin
            oa[i] = W'($urandom);
            ob[i] = W'($urandom);
            bus.a = oa[i];
            bus.b = ob[i];
            tick();
            ph = i % P;
            n_cmp++;
            if (bus.done !== (ph == W) || bus.busy !== (ph < W)) begin
                n_bad++;
                $display("FAIL held_handshake cycle %0d got busy=%b done=%b want %b %b",
                         i, bus.busy, bus.done, ph < W, ph == W);
            end
            if (ph == W) begin
                k = i - W;
                ref_sub(oa[k], ob[k], ed, eb, eo);
                n_cmp++;
                if ({bus.d, bus.bo, bus.ovf} !== {ed, eb, eo}) begin
                    n_bad++;
                    $display("FAIL held_result a=%0d b=%0d got d=%0d bo=%b ovf=%b want d=%0d bo=%b ovf=%b",
                             oa[k], ob[k], bus.d, bus.bo, bus.ovf, ed, eb, eo);
                end
            end
        end
        bus.start = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_reset_mid_run();
        logic [W-1:0] d, ed;
        logic         bo, ovf, eb, eo;
        int           nb, ov, seen;
        bit           tmo;
        bus.start = 1'b1;
        bus.a     = 4'd9;
        bus.b     = 4'd2;
        tick();
        bus.start = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        n_cmp++;
        if ({bus.d, bus.bo, bus.ovf, bus.busy, bus.done} !== '0) begin
            n_bad++;
            $display("FAIL midrun_reset got d=%h bo=%b ovf=%b busy=%b done=%b want all 0",
                     bus.d, bus.bo, bus.ovf, bus.busy, bus.done);
        end
        rst  = 1'b0;
        seen = 0;
        for (int i = 0; i < 2 * P; i++) begin
            tick();
            if (bus.done || bus.busy) seen++;
        end
        n_cmp++;
        if (seen !== 0) begin
            n_bad++;
            $display("FAIL midrun_no_done got active_cycles=%0d want 0", seen);
        end
        do_op(4'd6, 4'd9, d, bo, ovf, nb, ov, tmo);
        ref_sub(4'd6, 4'd9, ed, eb, eo);
        n_cmp++;
        if (tmo || {d, bo, ovf} !== {ed, eb, eo}) begin
            n_bad++;
            $display("FAIL midrun_restart got tmo=%b d=%0d bo=%b ovf=%b want d=%0d bo=%b ovf=%b",
                     tmo, d, bo, ovf, ed, eb, eo);
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] d, ed;
        logic         bo, ovf, eb, eo;
        int           nb, ov;
        bit           tmo;
        for (int i = 0; i < (1 << (2 * W)); i++) begin
            logic [W-1:0] a, b;
            a = W'(i >> W);
            b = W'(i);
            do_op(a, b, d, bo, ovf, nb, ov, tmo);
            ref_sub(a, b, ed, eb, eo);
            n_cmp++;
            if (tmo || ov != 0 || nb != W || {d, bo, ovf} !== {ed, eb, eo}) begin
                n_bad++;
                $display("FAIL exhaustive a=%0d b=%0d got tmo=%b busy=%0d ovl=%0d d=%0d bo=%b ovf=%b want d=%0d bo=%b ovf=%b",
                         a, b, tmo, nb, ov, d, bo, ovf, ed, eb, eo);
            end
        end
        tick();
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_directed();
        test_held_start();
        test_reset_mid_run();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
